// File: rtl/popcount_8bit_enum.sv
// Weight enumerator: streams every 8-bit word whose popcount equals the
// requested k, in ascending order, over a valid/ready handshake.
module popcount_8bit_enum #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 4,
    parameter int unsigned IDX_W = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] count,
    output logic             busy,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [IDX_W-1:0] out_index,
    output logic             out_last,
    output logic             done,
    output logic             err
);

    localparam int unsigned W1  = WIDTH + 1;
    localparam int unsigned SHW = $clog2(WIDTH);

    generate
        if (WIDTH != 8 || CNT_W != 4 || IDX_W != 7) begin : g_param_check
            $error("popcount_8bit_enum supports only WIDTH=8, CNT_W=4, IDX_W=7");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EMIT = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   k_q, k_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic [IDX_W-1:0]   index_q, index_d;
    logic               last_q, last_d;
    logic               valid_q, valid_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               err_q, err_d;

    logic [WIDTH-1:0]   lsb_c;
    logic [WIDTH-1:0]   ripple_c;
    logic [SHW-1:0]     ctz_c;
    logic [WIDTH-1:0]   next_word_c;

    // Smallest word of weight k: k ones packed at the bottom.
    function automatic logic [WIDTH-1:0] first_word(input logic [CNT_W-1:0] k);
        return WIDTH'((W1'(1) << k) - W1'(1));
    endfunction

    // Largest word of weight k: k ones packed at the top.
    function automatic logic [WIDTH-1:0] last_word(input logic [CNT_W-1:0] k);
        return first_word(k) << (CNT_W'(WIDTH) - k);
    endfunction

    // Gosper successor. The carry out of x + c is set only for the top word,
    // which never advances, so the sum is kept at WIDTH bits.
    always_comb begin
        lsb_c    = data_q & (~data_q + WIDTH'(1));
        ripple_c = data_q + lsb_c;
        ctz_c    = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (lsb_c[i]) begin
                ctz_c = SHW'(i);
            end
        end
        next_word_c = ripple_c | (((ripple_c ^ data_q) >> 2) >> ctz_c);
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        data_d  = data_q;
        index_d = index_q;
        last_d  = last_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        err_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (count > CNT_W'(WIDTH)) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = EMIT;
                        k_d     = count;
                        data_d  = first_word(count);
                        index_d = '0;
                        last_d  = (first_word(count) == last_word(count));
                        valid_d = 1'b1;
                        busy_d  = 1'b1;
                    end
                end
            end
            EMIT: begin
                if (valid_q && out_ready) begin
                    if (last_q) begin
                        state_d = DONE;
                        valid_d = 1'b0;
                        busy_d  = 1'b0;
                        last_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        data_d  = next_word_c;
                        index_d = index_q + IDX_W'(1);
                        last_d  = (next_word_c == last_word(k_q));
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            k_q     <= '0;
            data_q  <= '0;
            index_q <= '0;
            last_q  <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            data_q  <= data_d;
            index_q <= index_d;
            last_q  <= last_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign busy      = busy_q;
    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_index = index_q;
    assign out_last  = last_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_popcount_8bit_enum.sv
// Bench for popcount_8bit_enum: list-based reference model checked every
// cycle, plus literal expectations on the accepted word streams.
module tb_popcount_8bit_enum;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [3:0] count = 4'd0;
    logic       out_ready = 1'b0;
    logic       busy, out_valid, out_last, done, err;
    logic [7:0] out_data;
    logic [6:0] out_index;

    always #5 clk = ~clk;

    popcount_8bit_enum dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .count     (count),
        .busy      (busy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_index (out_index),
        .out_last  (out_last),
        .done      (done),
        .err       (err)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int popcnt(input int v);
        int c = 0;
        for (int i = 0; i < 8; i++) c += (v >> i) & 1;
        return c;
    endfunction

    // Reference model: the enumeration is simply every value 0..255 of weight k.
    bit m_active = 1'b0;
    bit m_done   = 1'b0;
    bit m_err    = 1'b0;
    bit m_old_done;
    int m_pos = 0;
    int m_k   = 0;
    int m_list[$];

    task automatic model_step();
        if (!rst_n) begin
            m_active = 1'b0;
            m_done   = 1'b0;
            m_err    = 1'b0;
            m_pos    = 0;
            m_list.delete();
            return;
        end
        m_old_done = m_done;
        m_done = 1'b0;
        m_err  = 1'b0;
        if (m_active) begin
            if (out_ready) begin
                if (m_pos == m_list.size() - 1) begin
                    m_active = 1'b0;
                    m_done   = 1'b1;
                end else begin
                    m_pos++;
                end
            end
        end else if (!m_old_done && start) begin
            if (int'(count) > 8) begin
                m_err = 1'b1;
            end else begin
                m_k = int'(count);
                m_list.delete();
                for (int v = 0; v < 256; v++) if (popcnt(v) == m_k) m_list.push_back(v);
                m_pos = 0;
                m_active = 1'b1;
            end
        end
    endtask

    initial forever begin
        @(posedge clk or negedge rst_n);
        model_step();
    end

    // Per-cycle comparison plus handshake invariants.
    int acc_q[$];
    bit p_valid = 1'b0;
    bit p_ready = 1'b0;
    int p_data  = 0;
    int p_index = 0;

    task automatic compare_step();
        check("valid", int'(out_valid), int'(m_active));
        check("busy",  int'(busy),      int'(m_active));
        check("done",  int'(done),      int'(m_done));
        check("err",   int'(err),       int'(m_err));
        if (m_active) begin
            check("data",   int'(out_data),  m_list[m_pos]);
            check("index",  int'(out_index), m_pos);
            check("last",   int'(out_last),  int'(m_pos == m_list.size() - 1));
            check("weight", popcnt(int'(out_data)), m_k);
        end
        if (p_valid && !p_ready && rst_n) begin
            check("hold_valid", int'(out_valid), 1);
            check("hold_data",  int'(out_data),  p_data);
            check("hold_index", int'(out_index), p_index);
        end
        if (out_valid && out_ready && rst_n) begin
            if (acc_q.size() > 0) check("ascending", int'(int'(out_data) > acc_q[$]), 1);
            acc_q.push_back(int'(out_data));
        end
        p_valid = out_valid && rst_n;
        p_ready = out_ready;
        p_data  = int'(out_data);
        p_index = int'(out_index);
    endtask

    initial forever begin
        @(negedge clk);
        compare_step();
    end

    function automatic int acc_at(input int i);
        return (i < acc_q.size()) ? acc_q[i] : -1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input string name, input bit rnd);
        int n = 0;
        while (!done && n < 2000) begin
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            tick();
            n++;
        end
        check({name, "_done_seen"}, int'(done), 1);
    endtask

    // Start an enumeration, drain it, and return aligned to an IDLE cycle.
    task automatic run_enum(input int k, input bit rnd);
        acc_q.delete();
        out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        count = 4'(k);
        start = 1'b1;
        tick();
        start = 1'b0;
        count = 4'($urandom_range(0, 15));
        wait_done("enum", rnd);
        tick();
    endtask

    int exp_k1[8]  = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
    int exp_k2[7]  = '{8'h03, 8'h05, 8'h06, 8'h09, 8'h0A, 8'h0C, 8'h11};
    int binom[9]   = '{1, 8, 28, 56, 70, 56, 28, 8, 1};
    int extra_k[4] = '{3, 5, 6, 7};

    initial begin
        int n;
        tick();
        check("rst_valid", int'(out_valid), 0);
        check("rst_busy",  int'(busy), 0);
        check("rst_data",  int'(out_data), 0);
        check("rst_index", int'(out_index), 0);
        check("rst_last",  int'(out_last), 0);
        check("rst_done",  int'(done), 0);
        check("rst_err",   int'(err), 0);
        tick();
        rst_n = 1'b1;
        tick();

        run_enum(0, 1'b0);
        check("k0_count", acc_q.size(), 1);
        check("k0_word",  acc_at(0), 8'h00);

        run_enum(1, 1'b0);
        check("k1_count", acc_q.size(), 8);
        for (int i = 0; i < 8; i++) check("k1_word", acc_at(i), exp_k1[i]);

        run_enum(2, 1'b0);
        check("k2_count", acc_q.size(), 28);
        for (int i = 0; i < 7; i++) check("k2_word", acc_at(i), exp_k2[i]);
        check("k2_final", acc_at(27), 8'hC0);

        run_enum(4, 1'b1);
        check("k4_count", acc_q.size(), 70);
        check("k4_first", acc_at(0), 8'h0F);
        check("k4_final", acc_at(69), 8'hF0);

        run_enum(8, 1'b0);
        check("k8_count", acc_q.size(), 1);
        check("k8_word",  acc_at(0), 8'hFF);

        foreach (extra_k[j]) begin
            run_enum(extra_k[j], 1'b0);
            check("kx_count", acc_q.size(), binom[extra_k[j]]);
        end

        // Out-of-range counts.
        count = 4'd9;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("err9_pulse", int'(err), 1);
        check("err9_valid", int'(out_valid), 0);
        check("err9_busy",  int'(busy), 0);
        tick();
        check("err9_clear", int'(err), 0);
        count = 4'd15;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("err15_pulse", int'(err), 1);
        check("err15_valid", int'(out_valid), 0);
        tick();
        check("err15_clear", int'(err), 0);

        // Start during EMIT, under backpressure and on the final handshake.
        acc_q.delete();
        out_ready = 1'b0;
        count = 4'd1;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        count = 4'd9;
        start = 1'b1;
        tick();
        check("mid_no_err", int'(err), 0);
        count = 4'd2;
        tick();
        wait_done("mid", 1'b0);
        start = 1'b0;
        check("mid_count", acc_q.size(), 8);
        tick();
        check("mid_no_restart", int'(out_valid), 0);
        tick();

        // Asynchronous abort partway through k=3.
        acc_q.delete();
        out_ready = 1'b1;
        count = 4'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (out_index != 7'd10 && n < 100) begin
            tick();
            n++;
        end
        check("abort_reached_10", int'(out_index), 10);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_valid", int'(out_valid), 0);
        check("abort_busy",  int'(busy), 0);
        check("abort_data",  int'(out_data), 0);
        check("abort_index", int'(out_index), 0);
        check("abort_last",  int'(out_last), 0);
        check("abort_done",  int'(done), 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check("abort_no_done", int'(done), 0);
        run_enum(3, 1'b0);
        check("restart_count", acc_q.size(), 56);
        check("restart_first", acc_at(0), 8'h07);
        check("restart_final", acc_at(55), 8'hE0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected summary");
        $fatal(1);
    end

endmodule
